// File: rtl/serial_frame_rx_if.sv
// Bit-stream input and parallel-word output bundle for serial_frame_rx.
// master drives the stream and consumes the word; slave is the receiver.
interface serial_frame_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  din;
  logic                  bit_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  busy;
  logic [7:0]            frame_count;

  modport master (
    output din, bit_en,
    input  data_out, data_valid, parity_err, busy, frame_count
  );

  modport slave (
    input  din, bit_en,
    output data_out, data_valid, parity_err, busy, frame_count
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, shifts in an MSB-first data word
// plus one parity bit, and presents good words with a one-cycle valid pulse.
//
//   state  | meaning
//   HUNT   | sliding-window search for SYNC_PATTERN
//   DATA   | shifting in DATA_WIDTH data bits
//   PARITY | waiting for the parity bit, then accept or reject the word
module serial_frame_rx #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_WIDTH   = 4,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'b1011,
  parameter bit                    PARITY_ODD   = 1'b0
) (
  input logic              clock,
  input logic              clear,
  serial_frame_rx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  state_t                state_q, state_d;
  logic [SYNC_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  busy_q, busy_d;
  logic [7:0]            fcnt_q, fcnt_d;

  logic [SYNC_WIDTH-1:0] sync_shift;
  logic [DATA_WIDTH-1:0] data_shift;
  logic                  parity_exp;

  assign sync_shift = {sync_q[SYNC_WIDTH-2:0], bus.din};
  assign data_shift = {data_q[DATA_WIDTH-2:0], bus.din};
  assign parity_exp = (^data_q) ^ PARITY_ODD;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= HUNT;
      sync_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    fcnt_d  = fcnt_q;
    if (bus.bit_en) begin
      unique case (state_q)
        HUNT: begin
          sync_d = sync_shift;
          if (sync_shift == SYNC_PATTERN) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          data_d = data_shift;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = PARITY;
        end
        PARITY: begin
          if (bus.din == parity_exp) begin
            dout_d  = data_q;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
          end else begin
            perr_d = 1'b1;
          end
          // Clearing the window prevents frame tail bits from seeding the next sync.
          state_d = HUNT;
          sync_d  = '0;
        end
        default: state_d = HUNT;
      endcase
    end
    busy_d = (state_d != HUNT);
  end

  assign bus.data_out    = dout_q;
  assign bus.data_valid  = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = fcnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with default parameters (8 data bits, sync 1011, even parity).
module tb_serial_frame_rx;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_perr = 0;
  int   n_both = 0;
  int   exp_fcnt = 0;

  serial_frame_rx_if #(.DATA_WIDTH(8)) bus ();

  serial_frame_rx #(
    .DATA_WIDTH  (8),
    .SYNC_WIDTH  (4),
    .SYNC_PATTERN(4'b1011),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.data_valid) n_valid++;
    if (bus.parity_err) n_perr++;
    if (bus.data_valid && bus.parity_err) n_both++;
  end

  task automatic drive_bit(input logic b, input logic en);
    @(negedge clock);
    bus.din = b;
    bus.bit_en = en;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    logic [12:0] fb;
    fb = {4'b1011, d, p};
    for (int k = 12; k >= 0; k--) drive_bit(fb[k], 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus.din = 1'b0;
    bus.bit_en = 1'b0;
    #3;
    checks++;
    if ({bus.busy, bus.data_valid, bus.parity_err, bus.frame_count, bus.data_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b dv=%b pe=%b fc=%0d do=%h required all zero",
               bus.busy, bus.data_valid, bus.parity_err, bus.frame_count, bus.data_out);
    end
    // Stream a sync word while held in reset; nothing may move.
    drive_bit(1'b1, 1'b1); drive_bit(1'b0, 1'b1); drive_bit(1'b1, 1'b1); drive_bit(1'b1, 1'b1);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_busy got %b required 0", bus.busy);
    end
    @(negedge clock);
    bus.bit_en = 1'b0;
    clear = 1'b1;
  endtask

  task automatic test_basic();
    logic [12:0] fb;
    fb = {4'b1011, 8'hA5, 1'b0};
    for (int k = 1; k <= 13; k++) begin
      drive_bit(fb[13-k], 1'b1);
      checks++;
      if (bus.busy !== (k >= 4 && k <= 12)) begin
        errors++;
        $display("FAIL basic_busy edge %0d got %b required %b", k, bus.busy, (k >= 4 && k <= 12));
      end
      checks++;
      if (bus.data_valid !== (k == 13)) begin
        errors++;
        $display("FAIL basic_valid edge %0d got %b required %b", k, bus.data_valid, (k == 13));
      end
    end
    exp_fcnt = 1;
    checks++;
    if (bus.data_out !== 8'hA5 || bus.frame_count !== 8'(exp_fcnt) || bus.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_word got do=%h fc=%0d pe=%b required do=a5 fc=%0d pe=0",
               bus.data_out, bus.frame_count, bus.parity_err, exp_fcnt);
    end
    drive_bit(1'b0, 1'b1);
    checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL basic_pulse_width got dv=%b do=%h required dv=0 do=a5", bus.data_valid, bus.data_out);
    end
  endtask

  task automatic test_parity_err();
    pulse_reset();
    exp_fcnt = 0;
    send_frame(8'hA5, 1'b1);
    checks++;
    if ({bus.parity_err, bus.data_valid, bus.data_out, bus.frame_count, bus.busy} !== {1'b1, 1'b0, 8'h00, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL perr_pulse got pe=%b dv=%b do=%h fc=%0d busy=%b required pe=1 dv=0 do=00 fc=0 busy=0",
               bus.parity_err, bus.data_valid, bus.data_out, bus.frame_count, bus.busy);
    end
    drive_bit(1'b1, 1'b1);
    checks++;
    if (bus.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_width got %b required 0", bus.parity_err);
    end
    drive_bit(1'b0, 1'b1); drive_bit(1'b1, 1'b1); drive_bit(1'b1, 1'b1);
    for (int k = 7; k >= 0; k--) drive_bit(1'(8'h3C >> k), 1'b1);
    drive_bit(1'b0, 1'b1);
    exp_fcnt = 1;
    checks++;
    if ({bus.data_valid, bus.parity_err, bus.data_out, bus.frame_count} !== {1'b1, 1'b0, 8'h3C, 8'(exp_fcnt)}) begin
      errors++;
      $display("FAIL perr_recover got dv=%b pe=%b do=%h fc=%0d required dv=1 pe=0 do=3c fc=%0d",
               bus.data_valid, bus.parity_err, bus.data_out, bus.frame_count, exp_fcnt);
    end
  endtask

  task automatic test_overlap();
    logic [14:0] s;
    s = {6'b101011, 8'h3C, 1'b0};
    drive_bit(1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      drive_bit(s[15-k], 1'b1);
      if (k == 5 || k == 6) begin
        checks++;
        if (bus.busy !== (k == 6)) begin
          errors++;
          $display("FAIL overlap_sync edge %0d busy got %b required %b", k, bus.busy, (k == 6));
        end
      end
      checks++;
      if (bus.data_valid !== (k == 15)) begin
        errors++;
        $display("FAIL overlap_valid edge %0d got %b required %b", k, bus.data_valid, (k == 15));
      end
    end
    exp_fcnt = 2;
    checks++;
    if (bus.data_out !== 8'h3C || bus.frame_count !== 8'(exp_fcnt)) begin
      errors++;
      $display("FAIL overlap_word got do=%h fc=%0d required do=3c fc=%0d", bus.data_out, bus.frame_count, exp_fcnt);
    end
  endtask

  task automatic test_bit_en_gaps();
    logic [12:0] fb;
    fb = {4'b1011, 8'hA5, 1'b0};
    pulse_reset();
    exp_fcnt = 0;
    for (int k = 1; k <= 13; k++) begin
      drive_bit(fb[13-k], 1'b1);
      checks++;
      if (bus.data_valid !== (k == 13) || bus.parity_err !== 1'b0) begin
        errors++;
        $display("FAIL gaps_enabled edge %0d got dv=%b pe=%b required dv=%b pe=0",
                 k, bus.data_valid, bus.parity_err, (k == 13));
      end
      drive_bit(1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (bus.data_valid !== 1'b0 || bus.busy !== (k >= 4 && k <= 12)) begin
        errors++;
        $display("FAIL gaps_hold edge %0d got dv=%b busy=%b required dv=0 busy=%b",
                 k, bus.data_valid, bus.busy, (k >= 4 && k <= 12));
      end
    end
    exp_fcnt = 1;
    checks++;
    if (bus.data_out !== 8'hA5 || bus.frame_count !== 8'(exp_fcnt)) begin
      errors++;
      $display("FAIL gaps_word got do=%h fc=%0d required do=a5 fc=%0d", bus.data_out, bus.frame_count, exp_fcnt);
    end
  endtask

  task automatic test_reset_mid();
    int v0, p0;
    logic [7:0] head;
    v0 = n_valid;
    p0 = n_perr;
    head = {4'b1011, 4'b0101};
    for (int k = 7; k >= 0; k--) drive_bit(head[k], 1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.frame_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_pre got busy=%b fc=%0d required busy=1 fc=1", bus.busy, bus.frame_count);
    end
    @(negedge clock);
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.data_out, bus.frame_count, bus.data_valid, bus.parity_err} !== 19'd0) begin
      errors++;
      $display("FAIL mid_async got busy=%b do=%h fc=%0d dv=%b pe=%b required all zero",
               bus.busy, bus.data_out, bus.frame_count, bus.data_valid, bus.parity_err);
    end
    @(negedge clock);
    clear = 1'b1;
    drive_bit(1'b0, 1'b1);
    checks++;
    if (n_valid !== v0 || n_perr !== p0) begin
      errors++;
      $display("FAIL mid_no_pulse got valid=%0d perr=%0d required valid=%0d perr=%0d", n_valid, n_perr, v0, p0);
    end
    send_frame(8'h5A, 1'b0);
    exp_fcnt = 1;
    checks++;
    if ({bus.data_valid, bus.data_out, bus.frame_count} !== {1'b1, 8'h5A, 8'(exp_fcnt)}) begin
      errors++;
      $display("FAIL mid_recover got dv=%b do=%h fc=%0d required dv=1 do=5a fc=%0d",
               bus.data_valid, bus.data_out, bus.frame_count, exp_fcnt);
    end
  endtask

  task automatic test_wrap();
    int p0;
    logic [7:0] d;
    pulse_reset();
    p0 = n_perr;
    for (int i = 1; i <= 256; i++) begin
      d = 8'(i * 37);
      send_frame(d, ^d);
      if (i == 255 || i == 256) begin
        checks++;
        if (bus.frame_count !== 8'(i) || bus.data_out !== d || bus.data_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap frame %0d got fc=%0d do=%h dv=%b required fc=%0d do=%h dv=1",
                   i, bus.frame_count, bus.data_out, bus.data_valid, 8'(i), d);
        end
      end
    end
    drive_bit(1'b0, 1'b1);
    checks++;
    if (n_perr !== p0 || n_both !== 0) begin
      errors++;
      $display("FAIL wrap_pulses got perr=%0d both=%0d required perr=%0d both=0", n_perr, n_both, p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_overlap();
    test_bit_en_gaps();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
